// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings and default sizes.
package fetch_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned TMR_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder/fetch-unit side bundle of the fetch sequencer: decode flags in, PC strobes and status out.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             start;
  logic             is_halt;
  logic             is_mem;
  logic             is_jump;
  logic             is_branch;
  logic             branch_taken;
  logic             mem_ack;
  logic             init_ctrl;
  logic             jump_ctrl;
  logic             branch_ctrl;
  logic             pc_hold;
  logic             done_ctrl;
  logic             mem_req;
  logic             error;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output start, is_halt, is_mem, is_jump, is_branch, branch_taken, mem_ack,
    input  init_ctrl, jump_ctrl, branch_ctrl, pc_hold, done_ctrl, mem_req, error,
           state, retired, stall_cycles
  );

  modport slave (
    input  start, is_halt, is_mem, is_jump, is_branch, branch_taken, mem_ack,
    output init_ctrl, jump_ctrl, branch_ctrl, pc_hold, done_ctrl, mem_req, error,
           state, retired, stall_cycles
  );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     count <= '0;
    else if (clear)                count <= '0;
    else if (inc && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC control sequencer: turns decode flags into fetch strobes, stalls on data-memory
// accesses under a watchdog, and keeps retired/stall performance counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic             clock,
  input logic             reset,
  fetch_sequencer_if.slave bus
);

  state_t           state, nxt;
  logic [TMR_W-1:0] timer;
  logic             timer_clr, timer_inc, cnt_clr, ret_inc, stall_inc;
  logic [CNT_W-1:0] retired, stall_cycles;
  logic             timeout;

  assign timeout = (timer == TMR_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Watchdog only advances while waiting on memory without an ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          timer <= '0;
    else if (timer_clr) timer <= '0;
    else if (timer_inc) timer <= timer + TMR_W'(1);
  end

  always_comb begin
    nxt             = state;
    bus.init_ctrl   = 1'b0;
    bus.jump_ctrl   = 1'b0;
    bus.branch_ctrl = 1'b0;
    bus.pc_hold     = 1'b1;
    bus.done_ctrl   = 1'b0;
    bus.mem_req     = 1'b0;
    bus.error       = 1'b0;
    timer_clr       = 1'b0;
    timer_inc       = 1'b0;
    cnt_clr         = 1'b0;
    ret_inc         = 1'b0;
    stall_inc       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) nxt = ST_INIT;
      end
      ST_INIT: begin
        bus.init_ctrl = 1'b1;
        bus.pc_hold   = 1'b0;
        cnt_clr       = 1'b1;
        timer_clr     = 1'b1;
        nxt           = ST_RUN;
      end
      ST_RUN: begin
        if (bus.is_halt) begin
          bus.done_ctrl = 1'b1;
          ret_inc       = 1'b1;
          nxt           = ST_HALT;
        end else if (bus.is_mem) begin
          bus.mem_req = 1'b1;
          timer_clr   = 1'b1;
          nxt         = ST_MEMWAIT;
        end else begin
          bus.pc_hold     = 1'b0;
          ret_inc         = 1'b1;
          bus.jump_ctrl   = bus.is_jump;
          bus.branch_ctrl = !bus.is_jump && bus.is_branch && bus.branch_taken;
        end
      end
      ST_MEMWAIT: begin
        bus.mem_req = 1'b1;
        stall_inc   = 1'b1;
        if (bus.mem_ack) begin
          bus.pc_hold = 1'b0;
          ret_inc     = 1'b1;
          nxt         = ST_RUN;
        end else if (timeout) begin
          nxt = ST_ERROR;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_HALT: begin
        bus.done_ctrl = 1'b1;
        if (bus.start) nxt = ST_INIT;
      end
      ST_ERROR: begin
        bus.error = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_retired (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (ret_inc),
    .count (retired)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  assign bus.state        = state;
  assign bus.retired      = retired;
  assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (4-bit counters, watchdog of 4 cycles).
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  fetch_sequencer_if #(.CNT_W(4)) bus ();

  fetch_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ctl bit order: init, jump, branch, pc_hold, done, mem_req, error
  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_HOLD = 7'b000_1000;
  localparam logic [6:0] C_INIT = 7'b100_0000;
  localparam logic [6:0] C_JUMP = 7'b010_0000;
  localparam logic [6:0] C_MEMH = 7'b000_1010;
  localparam logic [6:0] C_MEMA = 7'b000_0010;
  localparam logic [6:0] C_DONE = 7'b000_1100;
  localparam logic [6:0] C_ERR  = 7'b000_1001;

  function automatic logic [6:0] ctl();
    return {bus.init_ctrl, bus.jump_ctrl, bus.branch_ctrl, bus.pc_hold,
            bus.done_ctrl, bus.mem_req, bus.error};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic h, input logic m, input logic j,
                        input logic b, input logic t, input logic a);
    bus.start = s; bus.is_halt = h; bus.is_mem = m; bus.is_jump = j;
    bus.is_branch = b; bus.branch_taken = t; bus.mem_ack = a;
  endtask

  // Checks one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [6:0] c,
                            input logic [3:0] ret, input logic [3:0] stl);
    @(negedge clock);
    chk({tag, ".state"}, 16'(bus.state), 16'(st));
    chk({tag, ".ctl"}, 16'(ctl()), 16'(c));
    chk({tag, ".retired"}, 16'(bus.retired), 16'(ret));
    chk({tag, ".stall"}, 16'(bus.stall_cycles), 16'(stl));
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".state"}, 16'(bus.state), 16'd0);
    chk({tag, ".ctl"}, 16'(ctl()), 16'(C_HOLD));
    chk({tag, ".retired"}, 16'(bus.retired), 16'd0);
    chk({tag, ".stall"}, 16'(bus.stall_cycles), 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2;
    check_reset_vals("rst_async");
    do_reset();

    // start -> INIT -> 5 plain instructions
    expect_cyc("idle", 3'd0, C_HOLD, 0, 0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    expect_cyc("idle_start", 3'd0, C_HOLD, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("init", 3'd1, C_INIT, 0, 0);
    for (int i = 0; i < 5; i++) expect_cyc("plain", 3'd2, C_NONE, 4'(i), 0);

    // jump beats taken branch; untaken branch still retires
    set_in(0, 0, 0, 1, 1, 1, 0);
    expect_cyc("jump_br", 3'd2, C_JUMP, 5, 0);
    set_in(0, 0, 0, 0, 1, 0, 0);
    expect_cyc("br_ntkn", 3'd2, C_NONE, 6, 0);

    // memory access acked on 3rd MEMWAIT cycle
    set_in(0, 0, 1, 0, 0, 0, 0);
    expect_cyc("mem_run", 3'd2, C_MEMH, 7, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("mw1", 3'd3, C_MEMH, 7, 0);
    expect_cyc("mw2", 3'd3, C_MEMH, 7, 1);
    set_in(0, 0, 0, 0, 0, 0, 1);
    expect_cyc("mw3_ack", 3'd3, C_MEMA, 7, 2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("post_mem", 3'd2, C_NONE, 8, 3);

    // watchdog timeout -> ERROR, start ignored
    set_in(0, 0, 1, 0, 0, 0, 0);
    expect_cyc("to_run", 3'd2, C_MEMH, 9, 3);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) expect_cyc("to_mw", 3'd3, C_MEMH, 9, 4'(3 + i));
    set_in(1, 0, 0, 0, 0, 0, 1);
    expect_cyc("err1", 3'd5, C_ERR, 9, 7);
    expect_cyc("err2", 3'd5, C_ERR, 9, 7);
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    check_reset_vals("rst_err");

    // ack on final watchdog cycle wins
    set_in(1, 0, 0, 0, 0, 0, 0);
    expect_cyc("r2_idle", 3'd0, C_HOLD, 0, 0);
    set_in(0, 0, 1, 0, 0, 0, 0);
    expect_cyc("r2_init", 3'd1, C_INIT, 0, 0);
    expect_cyc("r2_mem", 3'd2, C_MEMH, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) expect_cyc("r2_mw", 3'd3, C_MEMH, 0, 4'(i));
    set_in(0, 0, 0, 0, 0, 0, 1);
    expect_cyc("r2_mw4_ack", 3'd3, C_MEMA, 0, 3);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("r2_run", 3'd2, C_NONE, 1, 4);

    // halt holds done; start restarts with cleared counters
    set_in(0, 1, 0, 0, 0, 0, 0);
    expect_cyc("halt_run", 3'd2, C_DONE, 2, 4);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("halt1", 3'd4, C_DONE, 3, 4);
    expect_cyc("halt2", 3'd4, C_DONE, 3, 4);
    set_in(1, 0, 0, 0, 0, 0, 0);
    expect_cyc("halt_start", 3'd4, C_DONE, 3, 4);
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_cyc("re_init", 3'd1, C_INIT, 3, 4);
    expect_cyc("re_run", 3'd2, C_NONE, 0, 0);

    // retired saturates at all-ones
    for (int i = 1; i <= 18; i++)
      expect_cyc("sat", 3'd2, C_NONE, (i > 15) ? 4'd15 : 4'(i), 0);

    // async reset in mid-MEMWAIT
    set_in(0, 0, 1, 0, 0, 0, 0);
    expect_cyc("ar_mem", 3'd2, C_MEMH, 15, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_memreq", 16'(bus.mem_req), 16'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid_mw");
    @(posedge clock);
    #1;
    reset = 1'b0;
    expect_cyc("ar_idle", 3'd0, C_HOLD, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
